// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register file dump reader: FSM encodings and default widths.
package reg_dump_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_DONE  = 3'd3,
        ST_CSUM  = 3'd4
    } state_t;

endpackage

// File: rtl/reg_file_dump.sv
// Walks a register range through one read port and streams (address, data) beats.
// Optional REG_DUMP_CSUM_EN appends an XOR checksum beat after the last register.
module reg_file_dump
    import reg_dump_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cur_addr_reg, cur_addr_next;
    logic [ADDR_W-1:0] lst_addr_reg, lst_addr_next;
    logic              out_valid_reg, out_valid_next;
    logic [ADDR_W-1:0] out_addr_reg, out_addr_next;
    logic [DATA_W-1:0] out_data_reg, out_data_next;
    logic              out_last_reg, out_last_next;
    logic              is_final;
`ifdef REG_DUMP_CSUM_EN
    logic [DATA_W-1:0] csum_reg, csum_next;
`endif

    assign is_final = (cur_addr_reg == lst_addr_reg);

    always_comb begin
        state_next     = state_reg;
        cur_addr_next  = cur_addr_reg;
        lst_addr_next  = lst_addr_reg;
        out_valid_next = out_valid_reg;
        out_addr_next  = out_addr_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;
`ifdef REG_DUMP_CSUM_EN
        csum_next      = csum_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_next = first_addr;
                    lst_addr_next = last_addr;
                    state_next    = ST_FETCH;
`ifdef REG_DUMP_CSUM_EN
                    csum_next     = '0;
`endif
                end
            end
            ST_FETCH: begin
                out_data_next  = rf_data;
                out_addr_next  = cur_addr_reg;
`ifdef REG_DUMP_CSUM_EN
                out_last_next  = 1'b0;
`else
                out_last_next  = is_final;
`endif
                out_valid_next = 1'b1;
                state_next     = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
`ifdef REG_DUMP_CSUM_EN
                    csum_next      = csum_reg ^ out_data_reg;
`endif
                    if (is_final) begin
`ifdef REG_DUMP_CSUM_EN
                        // Checksum beat follows immediately, carrying the folded total.
                        out_valid_next = 1'b1;
                        out_addr_next  = '0;
                        out_data_next  = csum_reg ^ out_data_reg;
                        out_last_next  = 1'b1;
                        state_next     = ST_CSUM;
`else
                        state_next     = ST_DONE;
`endif
                    end else begin
                        cur_addr_next = cur_addr_reg + ADDR_W'(1);
                        state_next    = ST_FETCH;
                    end
                end
            end
`ifdef REG_DUMP_CSUM_EN
            ST_CSUM: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                out_valid_next = 1'b0;
                state_next     = ST_IDLE;
            end
        endcase
        // Abort overrides any handshake taken in the same cycle.
        if (abort && (state_reg != ST_IDLE)) begin
            out_valid_next = 1'b0;
            state_next     = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cur_addr_reg  <= '0;
            lst_addr_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_addr_reg  <= '0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
`ifdef REG_DUMP_CSUM_EN
            csum_reg      <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            cur_addr_reg  <= cur_addr_next;
            lst_addr_reg  <= lst_addr_next;
            out_valid_reg <= out_valid_next;
            out_addr_reg  <= out_addr_next;
            out_data_reg  <= out_data_next;
            out_last_reg  <= out_last_next;
`ifdef REG_DUMP_CSUM_EN
            csum_reg      <= csum_next;
`endif
        end
    end

    assign rf_addr   = (state_reg == ST_IDLE) ? '0 : cur_addr_reg;
    assign out_valid = out_valid_reg;
    assign out_addr  = out_addr_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_reg_file_dump.sv
// Scoreboard bench for reg_file_dump: expected beats queued at start, checked on handshake.
module tb_reg_file_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b1;
    logic [4:0]  first_addr = '0;
    logic [4:0]  last_addr = '0;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] rf_mem [32];

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t exp_q [$];
    int checks = 0;
    int failures = 0;
    int beats_seen = 0;

    reg_file_dump dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    assign rf_data = rf_mem[rf_addr];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Handshakes complete at the next rising edge; abort cancels them.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready && !abort) begin
            beats_seen++;
            $display("beat addr=%0d data=%h last=%0b", out_addr, out_data, out_last);
            if (exp_q.size() == 0) begin
                check("sb_unexpected_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                check("beat_addr", 32'(out_addr), 32'(b.a));
                check("beat_data", out_data, b.d);
                check("beat_last", 32'(out_last), 32'(b.l));
            end
        end
    end

    task automatic push_expected(input logic [4:0] f, input logic [4:0] l, output int n);
        logic [4:0]  a;
        logic [31:0] x;
        beat_t       b;
        a = f;
        x = '0;
        n = 0;
        forever begin
            b.a = a;
            b.d = rf_mem[a];
`ifdef REG_DUMP_CSUM_EN
            b.l = 1'b0;
`else
            b.l = (a == l);
`endif
            x = x ^ b.d;
            exp_q.push_back(b);
            n++;
            if (a == l) break;
            a = a + 5'd1;
        end
`ifdef REG_DUMP_CSUM_EN
        b.a = '0;
        b.d = x;
        b.l = 1'b1;
        exp_q.push_back(b);
        n++;
`endif
    endtask

    task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int bp_addr,
                           input int bp_len, input bit mid_start, input bit abort_start,
                           output int cycles);
        int          n;
        int          first_v;
        bit          stalled;
        logic [4:0]  ha;
        logic [31:0] hd;
        beats_seen = 0;
        push_expected(f, l, n);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        abort      = abort_start;
        @(posedge clk);
        #1;
        start      = 1'b0;
        abort      = 1'b0;
        first_addr = ~f;
        cycles     = 1;
        first_v    = 0;
        stalled    = 1'b0;
        while (!done && cycles < 400) begin
            if (out_valid && first_v == 0) first_v = cycles;
            if (mid_start && cycles == 3) begin
                start      = 1'b1;
                first_addr = 5'd20;
                last_addr  = 5'd20;
            end else begin
                start = 1'b0;
            end
            if (!stalled && bp_len > 0 && out_valid && (32'(out_addr) == bp_addr)) begin
                out_ready = 1'b0;
                ha = out_addr;
                hd = out_data;
                for (int k = 0; k < bp_len; k++) begin
                    @(posedge clk);
                    #1;
                    cycles++;
                    check("bp_valid", 32'(out_valid), 32'd1);
                    check("bp_addr", 32'(out_addr), 32'(ha));
                    check("bp_data", out_data, hd);
                end
                out_ready = 1'b1;
                stalled   = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cycles++;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("first_valid_latency", 32'(first_v), 32'd2);
        check("beat_count", 32'(beats_seen), 32'(n));
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic wait_for_beat(input logic [4:0] a);
        int t;
        t = 0;
        while (!(out_valid && out_addr == a) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("beat_reached", 32'(out_valid && out_addr == a), 32'd1);
    endtask

    initial begin
        int  cyc;
        int  n;
        bit  saw_done;
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        rf_mem[15] = 32'hFFFF_FFFF;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rf_addr", 32'(rf_addr), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        rst = 1'b1;

        // Abort while idle does nothing
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd0);

        // Full dump, x15 all ones
        do_dump(5'd0, 5'd31, -1, 0, 1'b0, 1'b0, cyc);
`ifdef REG_DUMP_CSUM_EN
        check("full_cycles", 32'(cyc), 32'd66);
`else
        check("full_cycles", 32'(cyc), 32'd65);
`endif

        for (int i = 1; i < 32; i++) rf_mem[i] = $urandom;

        do_dump(5'd0, 5'd31, 3, 5, 1'b0, 1'b0, cyc);
        do_dump(5'd30, 5'd1, -1, 0, 1'b0, 1'b0, cyc);
        do_dump(5'd7, 5'd7, -1, 0, 1'b0, 1'b0, cyc);
        do_dump(5'd2, 5'd4, -1, 0, 1'b1, 1'b0, cyc);
        do_dump(5'd9, 5'd12, -1, 0, 1'b0, 1'b1, cyc);

        // Asynchronous reset in the middle of a dump
        beats_seen = 0;
        push_expected(5'd0, 5'd31, n);
        first_addr = 5'd0;
        last_addr  = 5'd31;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_for_beat(5'd10);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_addr", 32'(out_addr), 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_beats", 32'(beats_seen), 32'd10);
        exp_q.delete();
        saw_done = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            saw_done |= done;
        end
        rst = 1'b1;
        check("mid_rst_no_done", 32'(saw_done), 32'd0);
        do_dump(5'd3, 5'd5, -1, 0, 1'b0, 1'b0, cyc);

        // Abort on beat 5 while the consumer is ready
        beats_seen = 0;
        push_expected(5'd0, 5'd31, n);
        first_addr = 5'd0;
        last_addr  = 5'd31;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_for_beat(5'd5);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_beats", 32'(beats_seen), 32'd5);
        saw_done = done;
        repeat (4) begin
            @(posedge clk);
            #1;
            saw_done |= done;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        exp_q.delete();

`ifdef REG_DUMP_CSUM_EN
        rf_mem[1] = 32'h0000_00F0;
        rf_mem[2] = 32'h0000_000F;
        do_dump(5'd1, 5'd2, -1, 0, 1'b0, 1'b0, cyc);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
